// File: rtl/gpio_reg_responder.sv
// Responder for the MicroBlaze GPIO command link: decodes command words from gpo0,
// executes them against a local register file and returns acknowledge/read data on gpi0.
module gpio_reg_responder #(
   parameter int NB_GPIOS = 32,
   parameter int NB_DATA  = 16,
   parameter int N_REGS   = 8,
   parameter int NB_ADDR  = 3
) (
   input  logic                        clockdsp,
   input  logic                        in_reset,
   input  logic [NB_GPIOS-1:0]         in_gpo,
   output logic [NB_GPIOS-1:0]         out_gpi,
   input  logic [NB_DATA-1:0]          in_status,
   output logic [N_REGS*NB_DATA-1:0]   out_regs,
   output logic                        out_wr_pulse,
   output logic [NB_ADDR-1:0]          out_wr_addr,
   output logic [1:0]                  dbg_state
);

   // Handshake: the micro raises in_gpo[23] with a stable command word, waits for
   // out_gpi[23] (done), then drops the strobe; done falls after the strobe is seen low.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [7:0] OP_CLR    = 8'h01;
   localparam logic [7:0] OP_SETADR = 8'h02;
   localparam logic [7:0] OP_WRITE  = 8'h03;
   localparam logic [7:0] OP_READ   = 8'h04;
   localparam logic [7:0] OP_STATUS = 8'h05;

   state_t             state;
   logic               strobe_q;
   logic [7:0]         op_q;
   logic [15:0]        pay_q;
   logic [NB_ADDR-1:0] addr_q;
   logic [NB_DATA-1:0] rdata_q;
   logic [7:0]         op_echo;
   logic               err_q;
   logic               done_q;
   logic [NB_DATA-1:0] regs [N_REGS];

   logic strobe;
   logic strobe_rise;
   logic unused_bits;

   assign strobe      = in_gpo[23];
   assign strobe_rise = strobe & ~strobe_q;
   assign unused_bits = ^in_gpo[22:16];

   always_ff @(posedge clockdsp or negedge in_reset) begin
      if (!in_reset) begin
         state        <= S_IDLE;
         // Reset value of 1 keeps a strobe already high at release from looking like an edge
         strobe_q     <= 1'b1;
         op_q         <= '0;
         pay_q        <= '0;
         addr_q       <= '0;
         rdata_q      <= '0;
         op_echo      <= '0;
         err_q        <= 1'b0;
         done_q       <= 1'b0;
         out_wr_pulse <= 1'b0;
         out_wr_addr  <= '0;
         for (int k = 0; k < N_REGS; k++) regs[k] <= '0;
      end else begin
         strobe_q     <= strobe;
         out_wr_pulse <= 1'b0;
         case (state)
            S_IDLE: begin
               if (strobe_rise) begin
                  op_q         <= in_gpo[31:24];
                  pay_q        <= in_gpo[15:0];
                  out_wr_pulse <= (in_gpo[31:24] == OP_WRITE);
                  out_wr_addr  <= addr_q;
                  state        <= S_EXEC;
               end
            end
            S_EXEC: begin
               op_echo <= op_q;
               err_q   <= 1'b0;
               case (op_q)
                  OP_CLR: begin
                     for (int k = 0; k < N_REGS; k++) regs[k] <= '0;
                     addr_q <= '0;
                  end
                  OP_SETADR: begin
                     if ({16'h0, pay_q} < 32'(N_REGS)) addr_q <= pay_q[NB_ADDR-1:0];
                     else err_q <= 1'b1;
                  end
                  OP_WRITE:  regs[addr_q] <= pay_q[NB_DATA-1:0];
                  OP_READ:   rdata_q <= regs[addr_q];
                  OP_STATUS: rdata_q <= in_status;
                  default:   err_q <= 1'b1;
               endcase
               state <= S_DONE;
            end
            S_DONE: begin
               if (strobe) begin
                  done_q <= 1'b1;
               end else begin
                  done_q <= 1'b0;
                  state  <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      out_gpi        = '0;
      out_gpi[31:24] = op_echo;
      out_gpi[23]    = done_q;
      out_gpi[22]    = err_q;
      out_gpi[15:0]  = 16'(rdata_q);
   end

   for (genvar k = 0; k < N_REGS; k++) begin : g_regs
      assign out_regs[k*NB_DATA +: NB_DATA] = regs[k];
   end

   assign dbg_state = state;

endmodule
